// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: IDU opcodes, the IDU instruction record and scheduler defaults.
package gb_cpu_common_pkg;

   typedef enum logic [1:0] {
      IDU_NOP = 2'd0,
      IDU_INC = 2'd1,
      IDU_DEC = 2'd2
   } idu_opcode_t;

   typedef struct packed {
      idu_opcode_t op;
      logic [15:0] operand;
   } idu_instruction_t;

   localparam int IDU_SCHED_NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/gb_cpu_idu.sv
// Combinational 16-bit increment/decrement unit; results wrap modulo 2^16.
module gb_cpu_idu
   import gb_cpu_common_pkg::*;
(
   input  idu_instruction_t instr_i,
   output logic [15:0]      result_o
);

   always_comb begin
      result_o = instr_i.operand;
      case (instr_i.op)
         IDU_INC: result_o = instr_i.operand + 16'd1;
         IDU_DEC: result_o = instr_i.operand - 16'd1;
         default: result_o = instr_i.operand;
      endcase
   end

endmodule

// File: rtl/gb_cpu_idu_sched.sv
// Arbiter sharing one IDU among NUM_REQ requesters with a single result stage.
// Define IDU_SCHED_RR_EN for round-robin; default is fixed priority with starvation aging.
module gb_cpu_idu_sched
   import gb_cpu_common_pkg::*;
#(
   parameter int NUM_REQ      = IDU_SCHED_NUM_REQ_DEFAULT,
   parameter int STARVE_LIMIT = 3,
   localparam int IdW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_valid_i,
   input  idu_opcode_t        req_op_i      [NUM_REQ],
   input  logic [15:0]        req_operand_i [NUM_REQ],
   input  logic               stall_i,
   output logic [NUM_REQ-1:0] req_ready_o,
   output logic               rsp_valid_o,
   output logic [IdW-1:0]     rsp_id_o,
   output logic [15:0]        rsp_data_o
);

   logic             grantValid;
   logic [IdW-1:0]   grantIdx;
   logic [NUM_REQ-1:0] readyMask;

`ifdef IDU_SCHED_RR_EN
   logic [IdW-1:0] rrPtr_q;
   logic [IdW-1:0] rrPtr_d;
   int             cand;

   // Descending scan so the requester closest after the last grantee wins.
   always_comb begin
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rrPtr_q) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (req_valid_i[cand]) begin
            grantValid = 1'b1;
            grantIdx   = IdW'(cand);
         end
      end
      if (reset || stall_i) grantValid = 1'b0;
   end

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (grantValid) begin
         rrPtr_d = (grantIdx == IdW'(NUM_REQ - 1)) ? '0 : grantIdx + IdW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rrPtr_q <= '0;
      else       rrPtr_q <= rrPtr_d;
   end
`else
   localparam int CntW = $clog2(STARVE_LIMIT + 1);

   logic [CntW-1:0] waitCnt_q [NUM_REQ];
   logic [CntW-1:0] waitCnt_d [NUM_REQ];
   logic            starvedFound;
   logic [IdW-1:0]  starvedIdx;

   // A starved requester overrides plain lowest-index priority.
   always_comb begin
      grantValid   = 1'b0;
      grantIdx     = '0;
      starvedFound = 1'b0;
      starvedIdx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid_i[i]) begin
            grantValid = 1'b1;
            grantIdx   = IdW'(i);
            if (waitCnt_q[i] == CntW'(STARVE_LIMIT)) begin
               starvedFound = 1'b1;
               starvedIdx   = IdW'(i);
            end
         end
      end
      if (starvedFound) grantIdx = starvedIdx;
      if (reset || stall_i) grantValid = 1'b0;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         waitCnt_d[i] = waitCnt_q[i];
         if (!stall_i) begin
            if (!req_valid_i[i] || readyMask[i]) begin
               waitCnt_d[i] = '0;
            end else if (waitCnt_q[i] != CntW'(STARVE_LIMIT)) begin
               waitCnt_d[i] = waitCnt_q[i] + CntW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset) waitCnt_q[i] <= '0;
         else       waitCnt_q[i] <= waitCnt_d[i];
      end
   end
`endif

   always_comb begin
      readyMask = '0;
      if (grantValid) readyMask[grantIdx] = 1'b1;
   end

   assign req_ready_o = readyMask;

   idu_instruction_t stage_q;
   idu_instruction_t stage_d;
   logic [IdW-1:0]   stageId_q;
   logic             stageValid_q;

   always_comb begin
      stage_d.op      = req_op_i[grantIdx];
      stage_d.operand = req_operand_i[grantIdx];
   end

   // The stage only loads on a transfer, so rsp_id/rsp_data hold between results.
   always_ff @(posedge clk) begin
      if (reset) begin
         stageValid_q    <= 1'b0;
         stageId_q       <= '0;
         stage_q.op      <= IDU_NOP;
         stage_q.operand <= '0;
      end else begin
         stageValid_q <= grantValid;
         if (grantValid) begin
            stage_q   <= stage_d;
            stageId_q <= grantIdx;
         end
      end
   end

   gb_cpu_idu uIdu (
      .instr_i  (stage_q),
      .result_o (rsp_data_o)
   );

   assign rsp_valid_o = stageValid_q;
   assign rsp_id_o    = stageId_q;

endmodule

// File: tb/tb_gb_cpu_idu_sched.sv
// Directed bench for gb_cpu_idu_sched; aging sequences apply unless IDU_SCHED_RR_EN is defined.
module tb_gb_cpu_idu_sched;
   import gb_cpu_common_pkg::*;

   typedef struct {
      logic [3:0]  valid;
      idu_opcode_t op;
      logic [15:0] operand;
      logic        stall;
      logic [3:0]  expReady;
      logic        expRspValid;
      logic [1:0]  expId;
      logic [15:0] expData;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  reqValid;
   idu_opcode_t reqOp [4];
   logic [15:0] reqOperand [4];
   logic        stall;
   logic [3:0]  reqReady;
   logic        rspValid;
   logic [1:0]  rspId;
   logic [15:0] rspData;

   int testsRun = 0;
   int testsFailed = 0;

   gb_cpu_idu_sched #(.NUM_REQ(4), .STARVE_LIMIT(3)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid_i   (reqValid),
      .req_op_i      (reqOp),
      .req_operand_i (reqOperand),
      .stall_i       (stall),
      .req_ready_o   (reqReady),
      .rsp_valid_o   (rspValid),
      .rsp_id_o      (rspId),
      .rsp_data_o    (rspData)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input idu_opcode_t op,
                                input logic [15:0] opnd, input logic st);
      reqValid = v;
      stall    = st;
      for (int i = 0; i < 4; i++) begin
         reqOp[i]      = op;
         reqOperand[i] = opnd;
      end
   endtask

   // Checks the combinational grant, then the response one edge later.
   task automatic stepCycle(input string nm, input logic [3:0] expReady, input logic expRv,
                            input logic [1:0] expId, input logic [15:0] expData);
      #1;
      checkOutput({nm, " ready"}, 32'(reqReady), 32'(expReady));
      @(posedge clk);
      #1;
      checkOutput({nm, " rsp_valid"}, 32'(rspValid), 32'(expRv));
      checkOutput({nm, " rsp_id"}, 32'(rspId), 32'(expId));
      checkOutput({nm, " rsp_data"}, 32'(rspData), 32'(expData));
   endtask

   vec_t vecs [8];
   logic [1:0] order [6];

   initial begin
      vecs[0] = '{4'b0100, IDU_INC, 16'h1234, 1'b0, 4'b0100, 1'b1, 2'd2, 16'h1235};
      vecs[1] = '{4'b0001, IDU_INC, 16'hFFFF, 1'b0, 4'b0001, 1'b1, 2'd0, 16'h0000};
      vecs[2] = '{4'b0001, IDU_DEC, 16'h0000, 1'b0, 4'b0001, 1'b1, 2'd0, 16'hFFFF};
      vecs[3] = '{4'b0001, IDU_NOP, 16'hBEEF, 1'b0, 4'b0001, 1'b1, 2'd0, 16'hBEEF};
      vecs[4] = '{4'b1000, IDU_DEC, 16'h0001, 1'b0, 4'b1000, 1'b1, 2'd3, 16'h0000};
      vecs[5] = '{4'b0110, IDU_INC, 16'h00FF, 1'b0, 4'b0010, 1'b1, 2'd1, 16'h0100};
      vecs[6] = '{4'b0000, IDU_INC, 16'h5555, 1'b0, 4'b0000, 1'b0, 2'd1, 16'h0100};
      vecs[7] = '{4'b0010, IDU_INC, 16'h7777, 1'b1, 4'b0000, 1'b0, 2'd1, 16'h0100};

      reset = 1'b1;
      applyStimulus(4'b1111, IDU_NOP, 16'h0000, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("reset ready", 32'(reqReady), 32'h0);
      checkOutput("reset rsp_valid", 32'(rspValid), 32'h0);
      checkOutput("reset rsp_id", 32'(rspId), 32'h0);
      checkOutput("reset rsp_data", 32'(rspData), 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].op, vecs[i].operand, vecs[i].stall);
         stepCycle($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expRspValid,
                   vecs[i].expId, vecs[i].expData);
      end

`ifndef IDU_SCHED_RR_EN
      // req3 loses three cycles to req0, then is forced through once.
      applyStimulus(4'b1001, IDU_INC, 16'h0100, 1'b0);
      for (int c = 0; c < 6; c++) begin
         stepCycle($sformatf("contend%0d", c), (c == 3) ? 4'b1000 : 4'b0001, 1'b1,
                   (c == 3) ? 2'd3 : 2'd0, 16'h0101);
      end
      applyStimulus(4'b0000, IDU_NOP, 16'h0000, 1'b0);
      stepCycle("clear0", 4'b0000, 1'b0, 2'd0, 16'h0101);

      applyStimulus(4'b1111, IDU_INC, 16'h0200, 1'b0);
      stepCycle("prestall0", 4'b0001, 1'b1, 2'd0, 16'h0201);
      stepCycle("prestall1", 4'b0001, 1'b1, 2'd0, 16'h0201);
      stall = 1'b1;
      #1;
      checkOutput("stall inflight rsp_valid", 32'(rspValid), 32'h1);
      #1;
      for (int c = 0; c < 5; c++) begin
         stepCycle($sformatf("stall%0d", c), 4'b0000, 1'b0, 2'd0, 16'h0201);
      end
      stall = 1'b0;
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int c = 0; c < 6; c++) begin
         stepCycle($sformatf("poststall%0d", c), 4'b0001 << order[c], 1'b1, order[c], 16'h0201);
      end
      applyStimulus(4'b0000, IDU_NOP, 16'h0000, 1'b0);
      stepCycle("clear1", 4'b0000, 1'b0, 2'd1, 16'h0201);
`endif

      // Reset lands while a DEC result is in flight and req3 has aged.
      applyStimulus(4'b1010, IDU_DEC, 16'h0010, 1'b0);
      stepCycle("prereset0", 4'b0010, 1'b1, 2'd1, 16'h000F);
      stepCycle("prereset1", 4'b0010, 1'b1, 2'd1, 16'h000F);
      reset = 1'b1;
      stepCycle("midreset", 4'b0000, 1'b0, 2'd0, 16'h0000);
      reset = 1'b0;

`ifndef IDU_SCHED_RR_EN
      for (int c = 0; c < 4; c++) begin
         stepCycle($sformatf("postreset%0d", c), (c == 3) ? 4'b1000 : 4'b0010, 1'b1,
                   (c == 3) ? 2'd3 : 2'd1, 16'h000F);
      end
`else
      applyStimulus(4'b1111, IDU_INC, 16'h0300, 1'b0);
      for (int c = 0; c < 6; c++) begin
         stepCycle($sformatf("rr%0d", c), 4'b0001 << (c % 4), 1'b1, 2'(c % 4), 16'h0301);
      end
`endif

      applyStimulus(4'b0000, IDU_NOP, 16'h0000, 1'b0);
      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/gb_cpu_idu_sched.md
GB_CPU_IDU_SCHED -- requirements
Module: gb_cpu_idu_sched

Interface
REQ-001 Parameter NUM_REQ SHALL be: NUM_REQ, default 4, number of requesters sharing the IDU (index 0 = PC fetch, 1 = SP, 2 = HL, 3 = rr INC/DEC).
REQ-002 Parameter STARVE_LIMIT SHALL be: STARVE_LIMIT, default 3, consecutive lost eligible cycles before forced grant.
REQ-003 Port clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NUM_REQ  per-requester request.
REQ-006 Port req_op  input  NUM_REQ x idu_opcode_t  requested opcode (IDU_NOP/IDU_INC/IDU_DEC).
REQ-007 Port req_operand  input  NUM_REQ x 16  requested operand.
REQ-008 Port stall  input  1  freezes arbitration when high.
REQ-009 Port req_ready  output  NUM_REQ  one-hot-or-zero grant, combinational, same cycle as acceptance.
REQ-010 Port rsp_valid  output  1  result strobe.
REQ-011 Port rsp_id  output  $clog2(NUM_REQ)  index of requester owning result.
REQ-012 Port rsp_data  output  16  IDU result.

Function
REQ-013 Handshake: transfer occurs when req_valid[i] & req_ready[i]; requester SHALL hold op/operand until transfer or until it drops valid.
REQ-014 req_ready SHALL be all-zero when stall=1, reset=1 or req_valid=0; otherwise exactly one bit, for a valid requester.
REQ-015 Default arbitration: lowest valid index wins, unless a starved requester exists.
REQ-016 Per-requester wait counter: +1 each cycle valid & !ready & !stall, saturating at STARVE_LIMIT; cleared on grant or when valid low; unchanged when stall=1.
REQ-017 Requester with counter == STARVE_LIMIT is starved; lowest-index starved requester SHALL win over priority.
REQ-018 Accepted op, operand, and index SHALL be registered into a single stage; latency grant -> rsp_valid exactly 1 cycle.
REQ-019 rsp_valid SHALL be 1 the cycle after each transfer, 0 otherwise; no response back-pressure; stall SHALL NOT suppress an in-flight response.
REQ-020 rsp_data: NOP -> operand; INC -> operand+1 mod 2^16 (16'hFFFF -> 16'h0000); DEC -> operand-1 mod 2^16 (16'h0000 -> 16'hFFFF).
REQ-021 rsp_id/rsp_data SHALL hold last values while rsp_valid=0.
REQ-022 Back-to-back transfers SHALL be sustained: one grant per non-stalled cycle, throughput 1 op/cycle.

Reset
REQ-023 On reset: rsp_valid=0, rsp_id=0, rsp_data=16'h0000, all wait counters 0, RR pointer 0, stage register holds IDU_NOP/0.
REQ-024 Reset asserted with a response in flight SHALL discard it (rsp_valid=0 the following cycle); req_ready=0 during reset.

Configuration
REQ-025 Macro IDU_SCHED_RR_EN defined: round-robin arbitration, search starts at index after last grantee, wrapping; wait counters and REQ-015..017 removed.
REQ-026 Macro IDU_SCHED_RR_EN undefined: fixed priority with starvation aging per REQ-015..017.

Structure
REQ-027 Package gb_cpu_common_pkg SHALL hold idu_opcode_t, idu_instruction_t (reused) and new constant IDU_SCHED_NUM_REQ_DEFAULT.
REQ-028 Block SHALL instantiate one gb_cpu_idu sub-module, fed from the stage register; no other arithmetic duplicates it.

Verification
REQ-029 Single req: valid[2]=1, INC, 16'h1234 -> ready[2] same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=16'h1235.
REQ-030 Wrap: req0 INC 16'hFFFF -> rsp_data 16'h0000; req0 DEC 16'h0000 -> 16'hFFFF; NOP 16'hBEEF -> 16'hBEEF.
REQ-031 Contention (fixed priority): req0 and req3 valid continuously -> req0 granted cycles 0..2, req3 granted cycle 3 (STARVE_LIMIT=3), then req0 resumes.
REQ-032 Stall: all four valid, stall=1 for 5 cycles -> req_ready=0, no rsp_valid, counters frozen; stall release -> grant order resumes as before stall.
REQ-033 Reset mid-flight: grant req1 DEC 16'h0010, assert reset next cycle -> rsp_valid=0, rsp_data=16'h0000, counters 0.
REQ-034 With IDU_SCHED_RR_EN: all four valid continuously -> grant order 0,1,2,3,0,... one per cycle, rsp_id matching one cycle later.
